// File: rtl/servant_dbus_ic.sv
// Wishbone data-bus decoder: one master to N_SLAVES slaves selected by an address field; optional ack timeout via SERVANT_DBUS_IC_TIMEOUT_EN.
// Latency: slave cyc one cycle after master cyc, master ack one cycle after slave ack; unmapped accesses ack after one cycle.
// Backpressure: slave ack is the only flow control; ACTIVE holds until ack, master cyc drop, or (optionally) timeout.
module servant_dbus_ic #(
    parameter int                  N_SLAVES  = 4,
    parameter int                  SEL_LSB   = 28,
    parameter int                  SEL_WIDTH = 4,
    parameter logic [N_SLAVES-1:0] ACK_MASK  = '1,
    parameter int                  TIMEOUT   = 255
) (
    input  logic                     wb_clk,
    input  logic                     wb_rstn,
    input  logic [31:0]              i_wb_cpu_adr,
    input  logic [31:0]              i_wb_cpu_dat,
    input  logic [3:0]               i_wb_cpu_sel,
    input  logic                     i_wb_cpu_we,
    input  logic                     i_wb_cpu_cyc,
    output logic [31:0]              o_wb_cpu_rdt,
    output logic                     o_wb_cpu_ack,
    output logic [31:0]              o_wb_s_adr,
    output logic [31:0]              o_wb_s_dat,
    output logic [3:0]               o_wb_s_sel,
    output logic                     o_wb_s_we,
    output logic [N_SLAVES-1:0]      o_wb_s_cyc,
    input  logic [32*N_SLAVES-1:0]   i_wb_s_rdt,
    input  logic [N_SLAVES-1:0]      i_wb_s_ack,
    output logic                     o_bus_err,
    output logic [7:0]               o_err_count
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t               state, state_nxt;
    logic [SEL_WIDTH-1:0] idx;
    logic [SEL_WIDTH-1:0] adr_idx;
    logic                 adr_mapped;
    logic [31:0]          rdt_q;
    logic                 err_q;
    logic                 sel_ack;
    logic                 sel_auto;
    logic [31:0]          sel_rdt;
    logic                 sel_done;
    logic                 to_hit;
    logic                 err_enter;

    generate
        if (N_SLAVES < 2 || N_SLAVES > 16 || TIMEOUT < 1 || TIMEOUT > 65535 ||
            (1 << SEL_WIDTH) < N_SLAVES) begin : g_bad_param
            $error("servant_dbus_ic: illegal parameter combination");
        end
    endgenerate

    assign o_wb_s_adr = i_wb_cpu_adr;
    assign o_wb_s_dat = i_wb_cpu_dat;
    assign o_wb_s_sel = i_wb_cpu_sel;
    assign o_wb_s_we  = i_wb_cpu_we;

    assign adr_idx    = i_wb_cpu_adr[SEL_LSB +: SEL_WIDTH];
    assign adr_mapped = {1'b0, adr_idx} < (SEL_WIDTH+1)'(N_SLAVES);

    // Per-slave view of the latched target; slaves outside ACK_MASK are acked by us.
    always_comb begin
        sel_ack  = 1'b0;
        sel_auto = 1'b0;
        sel_rdt  = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx == SEL_WIDTH'(i)) begin
                sel_ack  = i_wb_s_ack[i];
                sel_auto = !ACK_MASK[i];
                sel_rdt  = i_wb_s_rdt[32*i +: 32];
            end
        end
    end

    assign sel_done = sel_auto || sel_ack;

`ifdef SERVANT_DBUS_IC_TIMEOUT_EN
    logic [15:0] to_cnt;

    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn)
            to_cnt <= '0;
        else if (state != ACTIVE)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 16'd1;
    end

    assign to_hit = (to_cnt == 16'(TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_wb_cpu_cyc) state_nxt = adr_mapped ? ACTIVE : RESP;
            ACTIVE: begin
                if (!i_wb_cpu_cyc)
                    state_nxt = IDLE;
                else if (sel_done || to_hit)
                    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_wb_cpu_ack = (state == RESP);
        o_bus_err    = (state == RESP) && err_q;
        o_wb_s_cyc   = '0;
        for (int i = 0; i < N_SLAVES; i++)
            o_wb_s_cyc[i] = (state == ACTIVE) && i_wb_cpu_cyc && (idx == SEL_WIDTH'(i));
    end

    assign err_enter = ((state == IDLE) && i_wb_cpu_cyc && !adr_mapped) ||
                       ((state == ACTIVE) && i_wb_cpu_cyc && !sel_done && to_hit);

    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn) begin
            idx   <= '0;
            rdt_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_wb_cpu_cyc) begin
                        idx   <= adr_idx;
                        err_q <= !adr_mapped;
                        if (!adr_mapped)
                            rdt_q <= '0;
                    end
                end
                ACTIVE: begin
                    if (i_wb_cpu_cyc && sel_done) begin
                        rdt_q <= sel_rdt;
                        err_q <= 1'b0;
                    end else if (i_wb_cpu_cyc && to_hit) begin
                        rdt_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counted as the error response is committed, so it is visible during RESP.
    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn)
            o_err_count <= '0;
        else if (err_enter && o_err_count != 8'hff)
            o_err_count <= o_err_count + 8'd1;
    end

    assign o_wb_cpu_rdt = rdt_q;

endmodule

// File: tb/tb_servant_dbus_ic.sv
// Self-checking bench for servant_dbus_ic: directed scenarios then randomized transactions against a transaction-level model.
module tb_servant_dbus_ic;

    localparam logic [3:0] ACK_MASK = 4'b1011;
    localparam int         TIMEOUT  = 8;
`ifdef SERVANT_DBUS_IC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         wb_clk = 1'b0;
    logic         wb_rstn;
    logic [31:0]  cpu_adr, cpu_dat, cpu_rdt;
    logic [3:0]   cpu_sel;
    logic         cpu_we, cpu_cyc, cpu_ack;
    logic [31:0]  s_adr, s_dat;
    logic [3:0]   s_sel;
    logic         s_we;
    logic [3:0]   s_cyc;
    logic [127:0] s_rdt;
    logic [3:0]   s_ack;
    logic         bus_err;
    logic [7:0]   err_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 wb_clk = ~wb_clk;

    servant_dbus_ic #(
        .N_SLAVES (4),
        .SEL_LSB  (28),
        .SEL_WIDTH(4),
        .ACK_MASK (ACK_MASK),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .wb_clk      (wb_clk),
        .wb_rstn     (wb_rstn),
        .i_wb_cpu_adr(cpu_adr),
        .i_wb_cpu_dat(cpu_dat),
        .i_wb_cpu_sel(cpu_sel),
        .i_wb_cpu_we (cpu_we),
        .i_wb_cpu_cyc(cpu_cyc),
        .o_wb_cpu_rdt(cpu_rdt),
        .o_wb_cpu_ack(cpu_ack),
        .o_wb_s_adr  (s_adr),
        .o_wb_s_dat  (s_dat),
        .o_wb_s_sel  (s_sel),
        .o_wb_s_we   (s_we),
        .o_wb_s_cyc  (s_cyc),
        .i_wb_s_rdt  (s_rdt),
        .i_wb_s_ack  (s_ack),
        .o_bus_err   (bus_err),
        .o_err_count (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"},   32'(cpu_ack),   32'd0);
        chk({tag, "_rdt"},   cpu_rdt,        32'd0);
        chk({tag, "_s_cyc"}, 32'(s_cyc),     32'd0);
        chk({tag, "_err"},   32'(bus_err),   32'd0);
        chk({tag, "_cnt"},   32'(err_count), 32'd0);
    endtask

    // One master transaction. Called at a falling edge. d = cycles the target slave
    // waits before acking (negative = never). Expectations come from the access rules only.
    task automatic txn(input logic [31:0] adr, input logic we, input int d, input logic [31:0] tgt_rdt);
        int         idx;
        int         exp_cyc;
        logic       exp_err;
        logic [31:0] exp_rdt;
        logic [3:0] exp_scyc;
        bit         own_ack;
        idx = int'(adr[31:28]);
        for (int i = 0; i < 4; i++)
            s_rdt[32*i +: 32] = (i == idx) ? tgt_rdt : $urandom;
        exp_err = 1'b0;
        exp_rdt = tgt_rdt;
        own_ack = (idx < 4) && ACK_MASK[idx[1:0]];
        if (idx >= 4) begin
            exp_cyc = 1; exp_err = 1'b1; exp_rdt = 32'd0;
        end else if (!own_ack) begin
            exp_cyc = 2;
        end else if (TO_EN && (d < 0 || d >= TIMEOUT)) begin
            exp_cyc = TIMEOUT + 1; exp_err = 1'b1; exp_rdt = 32'd0;
        end else begin
            exp_cyc = 2 + d;
        end
        if (exp_err)
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;

        cpu_adr = adr;
        cpu_we  = we;
        cpu_dat = $urandom;
        cpu_sel = 4'($urandom);
        cpu_cyc = 1'b1;
        for (int c = 0; c <= exp_cyc; c++) begin
            s_ack = 4'($urandom);
            if (own_ack && c > 0)
                s_ack[idx[1:0]] = (d >= 0 && c >= 1 + d);
            #1;
            exp_scyc = (idx < 4 && c >= 1 && c < exp_cyc) ? 4'(1 << idx) : 4'b0;
            chk("s_cyc", 32'(s_cyc), 32'(exp_scyc));
            chk("ack_timing", 32'(cpu_ack), 32'(c == exp_cyc));
            chk("bus_err", 32'(bus_err), 32'(c == exp_cyc && exp_err));
            if (c == 0) begin
                chk("bcast_adr", s_adr, cpu_adr);
                chk("bcast_dat", s_dat, cpu_dat);
                chk("bcast_sel", 32'(s_sel), 32'(cpu_sel));
                chk("bcast_we",  32'(s_we), 32'(cpu_we));
            end
            if (c == exp_cyc) begin
                if (!we || exp_err)
                    chk("rdt", cpu_rdt, exp_rdt);
                chk("err_count", 32'(err_count), 32'(exp_cnt));
                cpu_cyc = 1'b0;
                s_ack   = 4'b0;
            end
            @(negedge wb_clk);
        end
        #1;
        chk("ack_single", 32'(cpu_ack), 32'd0);
        @(negedge wb_clk);
    endtask

    initial begin
        int hits;
        logic [31:0] adr;
        int d;

        wb_rstn = 1'b0;
        cpu_adr = '0; cpu_dat = '0; cpu_sel = '0; cpu_we = 1'b0; cpu_cyc = 1'b0;
        s_rdt = '0; s_ack = '0;
        #1;
        chk_reset_vals("reset");
        @(negedge wb_clk);
        wb_rstn = 1'b1;
        @(negedge wb_clk);

        // Slave 1 read acked in its first cycle.
        txn(32'h1000_0004, 1'b0, 0, 32'hCAFE_F00D);
        // Slave with interconnect-generated ack, write.
        txn(32'h2000_0000, 1'b1, 0, 32'h1234_5678);
        // Unmapped read, then drive the counter into saturation.
        txn(32'h5000_0000, 1'b0, 0, 32'hDEAD_BEEF);
        for (int n = 1; n < 300; n++)
            txn({4'($urandom_range(4, 15)), 28'($urandom)}, 1'($urandom), 0, $urandom);
        chk("err_saturated", 32'(err_count), 32'd255);

        // Slave 0 never acks.
        if (TO_EN) begin
            txn(32'h0000_0010, 1'b0, -1, 32'h0BAD_0BAD);
        end else begin
            cpu_adr = 32'h0000_0010; cpu_we = 1'b0; cpu_cyc = 1'b1; s_ack = 4'b0;
            hits = 0;
            for (int c = 0; c < 1000; c++) begin
                #1;
                if (cpu_ack) hits++;
                @(negedge wb_clk);
            end
            chk("no_ack_1000", 32'(hits), 32'd0);
            chk("still_active", 32'(s_cyc), 32'b0001);
            cpu_cyc = 1'b0;
            #1;
            chk("cyc_drop_comb", 32'(s_cyc), 32'd0);
            @(negedge wb_clk);
            @(negedge wb_clk);
        end

        // Master abandons slave 3 in its second ACTIVE cycle as the slave acks.
        cpu_adr = 32'h3000_0000; cpu_we = 1'b0; cpu_cyc = 1'b1; s_ack = 4'b0;
        @(negedge wb_clk);
        #1;
        chk("abort_scyc1", 32'(s_cyc), 32'b1000);
        @(negedge wb_clk);
        cpu_cyc = 1'b0; s_ack = 4'b1000;
        #1;
        chk("abort_scyc2", 32'(s_cyc), 32'd0);
        hits = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge wb_clk);
            #1;
            if (cpu_ack || bus_err) hits++;
        end
        s_ack = 4'b0;
        chk("abort_no_ack", 32'(hits), 32'd0);
        chk("abort_cnt", 32'(err_count), 32'(exp_cnt));
        @(negedge wb_clk);
        txn(32'h1000_0000, 1'b0, 1, 32'h5555_AAAA);

        // Reset in the middle of a slave 0 access.
        cpu_adr = 32'h0000_0000; cpu_cyc = 1'b1; s_ack = 4'b0;
        @(negedge wb_clk);
        #1;
        chk("rst_pre_scyc", 32'(s_cyc), 32'b0001);
        #1;
        wb_rstn = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        exp_cnt = 0;
        cpu_cyc = 1'b0;
        @(negedge wb_clk);
        wb_rstn = 1'b1;
        hits = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge wb_clk);
            #1;
            if (cpu_ack || s_cyc != 4'b0) hits++;
        end
        chk("rst_no_ack", 32'(hits), 32'd0);
        @(negedge wb_clk);

        for (int n = 0; n < 60; n++) begin
            adr = {4'($urandom_range(0, 7)), 28'($urandom)};
            if (TO_EN)
                d = ($urandom_range(0, 9) == 9) ? -1 : int'($urandom_range(0, 10));
            else
                d = int'($urandom_range(0, 6));
            txn(adr, 1'($urandom), d, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servant_dbus_ic.md
SERVANT_DBUS_IC -- requirements
Module: servant_dbus_ic

Interface
REQ-001 SHALL have parameter N_SLAVES, default 4, number of slave ports (legal 2..16).
REQ-002 SHALL have parameter SEL_LSB, default 28, lowest address bit of the slave-select field.
REQ-003 SHALL have parameter SEL_WIDTH, default 4, width of the slave-select field (2**SEL_WIDTH >= N_SLAVES).
REQ-004 SHALL have parameter ACK_MASK, default all ones [N_SLAVES-1:0], where bit i=1 means slave i drives its own ack and bit i=0 means the interconnect generates ack.
REQ-005 SHALL have parameter TIMEOUT, default 255, slave-ack timeout in cycles (1..65535).
REQ-006 Ports:
- wb_clk  in  1  clock
- wb_rstn  in  1  asynchronous active-low reset
- i_wb_cpu_adr/dat  in  32  master address/write data
- i_wb_cpu_sel  in  4  byte enables
- i_wb_cpu_we, i_wb_cpu_cyc  in  1  write, cycle
- o_wb_cpu_rdt  out  32  read data
- o_wb_cpu_ack  out  1  ack
- o_wb_s_adr/dat  out  32  broadcast to all slaves
- o_wb_s_sel  out  4  broadcast
- o_wb_s_we  out  1  broadcast
- o_wb_s_cyc  out  N_SLAVES  per-slave cycle
- i_wb_s_rdt  in  32*N_SLAVES  slave i at [32*i+:32]
- i_wb_s_ack  in  N_SLAVES  per-slave ack
- o_bus_err  out  1  one-cycle error pulse
- o_err_count  out  8  saturating error count

Function
REQ-007 Broadcast outputs SHALL equal the master inputs combinationally.
REQ-008 FSM states SHALL be IDLE, ACTIVE, RESP.
REQ-009 In IDLE with i_wb_cpu_cyc=1, idx=adr[SEL_LSB+:SEL_WIDTH] SHALL be latched; idx<N_SLAVES -> ACTIVE, otherwise -> RESP with err set.
REQ-010 o_wb_s_cyc[i] SHALL be 1 only in ACTIVE with latched idx==i and i_wb_cpu_cyc=1.
REQ-011 In ACTIVE with ACK_MASK[idx]=1 and i_wb_s_ack[idx]=1, rdt SHALL be captured from slave idx and the FSM SHALL go to RESP.
REQ-012 In ACTIVE with ACK_MASK[idx]=0, rdt SHALL be captured on the first ACTIVE cycle and the FSM SHALL go to RESP (i_wb_s_ack[idx] ignored).
REQ-013 In RESP, o_wb_cpu_ack SHALL be 1 for exactly one cycle with registered rdt; next state IDLE.
REQ-014 Minimum latency: cyc sampled at cycle 0, slave cyc at cycle 1, ack at cycle 2 when the slave acks in its first cycle; an unmapped access acks at cycle 1.
REQ-015 An error response SHALL return rdt=32'h0, pulse o_bus_err in the RESP cycle, and increment o_err_count, saturating at 255.
REQ-016 i_wb_cpu_cyc falling in ACTIVE SHALL return the FSM to IDLE with no ack, no error, and a discarded slave ack.
REQ-017 i_wb_s_ack on a non-selected slave, or in IDLE/RESP, SHALL be ignored.
REQ-018 Writes SHALL acknowledge identically to reads, with rdt unspecified but stable.

Reset
REQ-019 Asserting wb_rstn=0 SHALL asynchronously force IDLE, o_wb_cpu_ack=0, o_wb_cpu_rdt=0, o_wb_s_cyc=0, o_bus_err=0, o_err_count=0, timeout counter=0, idx=0.
REQ-020 Reset asserted mid-transaction SHALL drop slave cyc immediately and produce no ack after release.

Configuration
REQ-021 With SERVANT_DBUS_IC_TIMEOUT_EN defined, a counter SHALL clear on ACTIVE entry and increment each ACTIVE cycle; if it reaches TIMEOUT with no ack, the FSM SHALL go to RESP with err (REQ-015).
REQ-022 Without SERVANT_DBUS_IC_TIMEOUT_EN, ACTIVE SHALL wait indefinitely, no counter logic SHALL be present, and errors SHALL arise only from unmapped accesses.

Verification
REQ-023 Read adr=0x1000_0004 with slave1 acking in its first cycle and rdt=0xCAFE_F00D -> o_wb_s_cyc=4'b0010 at cycle 1, ack at cycle 2, rdt=0xCAFE_F00D.
REQ-024 ACK_MASK=4'b1011, write to adr=0x2000_0000 -> o_wb_s_cyc[2] for one cycle, ack at cycle 2, no error.
REQ-025 Read adr=0x5000_0000 (N_SLAVES=4) -> ack at cycle 1, rdt=0, o_bus_err pulse, o_err_count=1; 300 such accesses -> o_err_count=255.
REQ-026 With TIMEOUT_EN and TIMEOUT=8, slave0 never acks -> ack with err exactly 8 ACTIVE cycles after entry; without the macro, no ack after 1000 cycles.
REQ-027 Drop cyc in the second ACTIVE cycle while slave3 acks in the same cycle -> no master ack, FSM in IDLE, o_err_count unchanged.
REQ-028 Assert wb_rstn=0 during ACTIVE -> o_wb_s_cyc=0 in the same cycle, all outputs at reset values, and no ack after release.
